if_id_stage: RTL and testbench

Fetch/decode boundary register for the single-issue MIPS datapath. It sits directly downstream of the program counter and instruction memory. Each cycle it captures the fetched instruction word and its PC+4 value, and presents them to the decode stage over a valid/ready handshake. A two-entry skid buffer keeps its upstream ready signal fully registered. It also supports branch flush and counts decode-stall cycles for the lab's performance report.

---
 rtl/if_id_pkg.sv | 14 +
 rtl/if_id_slot.sv | 37 +++
 rtl/if_id_stage.sv | 153 +++++++++++++++
 tb/tb_if_id_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_pkg.sv
// Shared definitions for the IF/ID boundary register: state encodings,
// the NOP pattern loaded on flush, and default widths.
package if_id_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int CNT_W_DEFAULT  = 16;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage : if_id_pkg

// File: rtl/if_id_slot.sv
// One holding entry of the IF/ID register: PC+4 plus instruction word.
// Clear has priority over load and returns the entry to a NOP.
module if_id_slot
    import if_id_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              Clk,
    input  logic              Clear,
    input  logic              Load,
    input  logic [DATA_W-1:0] DPCPlus4,
    input  logic [DATA_W-1:0] DInstruction,
    output logic [DATA_W-1:0] QPCPlus4,
    output logic [DATA_W-1:0] QInstruction
);

    logic [DATA_W-1:0] pc_plus4_r;
    logic [DATA_W-1:0] instruction_r;

    // Entry storage: clear to NOP, otherwise capture on load, otherwise hold.
    always_ff @(posedge Clk) begin
        if (Clear) begin
            pc_plus4_r    <= {DATA_W{1'b0}};
            instruction_r <= DATA_W'(NOP_INSTR);
        end else if (Load) begin
            pc_plus4_r    <= DPCPlus4;
            instruction_r <= DInstruction;
        end else begin
            pc_plus4_r    <= pc_plus4_r;
            instruction_r <= instruction_r;
        end
    end

    assign QPCPlus4     = pc_plus4_r;
    assign QInstruction = instruction_r;

endmodule : if_id_slot

// File: rtl/if_id_stage.sv
// IF/ID boundary register with a two-entry skid buffer. MAIN drives the
// decode-side ports, SKID absorbs the one word accepted while decode stalls,
// so InReady can come straight from a flop. Also counts decode stalls.
module if_id_stage
    import if_id_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InValid,
    input  logic [DATA_W-1:0] InPCPlus4,
    input  logic [DATA_W-1:0] InInstruction,
    output logic              InReady,
    output logic              OutValid,
    output logic [DATA_W-1:0] OutPCPlus4,
    output logic [DATA_W-1:0] OutInstruction,
    input  logic              OutReady,
    input  logic              Flush,
    output logic [CNT_W-1:0]  StallCount
);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [CNT_W-1:0]  stall_count_r;

    logic              in_fire_s;
    logic              out_fire_s;
    logic              main_load_s;
    logic              main_from_skid_s;
    logic              skid_load_s;
    logic              slot_clear_s;

    logic [DATA_W-1:0] skid_pc_plus4_s;
    logic [DATA_W-1:0] skid_instruction_s;
    logic [DATA_W-1:0] main_d_pc_plus4_s;
    logic [DATA_W-1:0] main_d_instruction_s;

    assign in_fire_s    = InValid & in_ready_r;
    assign out_fire_s   = out_valid_r & OutReady;
    assign slot_clear_s = Reset | Flush;

    // Next-state and entry load decisions; flush overrides every transition.
    always_comb begin
        state_nxt_s      = state_r;
        main_load_s      = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        if (Flush) begin
            state_nxt_s = S_EMPTY;
        end else begin
            case (state_r)
                S_EMPTY: begin
                    if (in_fire_s) begin
                        state_nxt_s = S_ONE;
                        main_load_s = 1'b1;
                    end else begin
                        state_nxt_s = S_EMPTY;
                    end
                end
                S_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        state_nxt_s = S_ONE;
                        main_load_s = 1'b1;
                    end else if (in_fire_s) begin
                        state_nxt_s = S_TWO;
                        skid_load_s = 1'b1;
                    end else if (out_fire_s) begin
                        state_nxt_s = S_EMPTY;
                    end else begin
                        state_nxt_s = S_ONE;
                    end
                end
                S_TWO: begin
                    // InReady is low here, so only the drain move is possible.
                    if (out_fire_s) begin
                        state_nxt_s      = S_ONE;
                        main_load_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = S_TWO;
                    end
                end
                default: begin
                    state_nxt_s = S_EMPTY;
                end
            endcase
        end
    end

    // MAIN takes the older SKID word when draining, otherwise the fetch word.
    always_comb begin
        if (main_from_skid_s) begin
            main_d_pc_plus4_s    = skid_pc_plus4_s;
            main_d_instruction_s = skid_instruction_s;
        end else begin
            main_d_pc_plus4_s    = InPCPlus4;
            main_d_instruction_s = InInstruction;
        end
    end

    // State register plus flopped valid/ready decoded from the next state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r     <= S_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s != S_EMPTY);
            in_ready_r  <= (state_nxt_s != S_TWO);
        end
    end

    // Saturating count of cycles where decode holds off a valid word.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (out_valid_r && !OutReady && (stall_count_r != {CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + CNT_W'(1);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    if_id_slot #(.DATA_W(DATA_W)) u_main (
        .Clk          (Clk),
        .Clear        (slot_clear_s),
        .Load         (main_load_s),
        .DPCPlus4     (main_d_pc_plus4_s),
        .DInstruction (main_d_instruction_s),
        .QPCPlus4     (OutPCPlus4),
        .QInstruction (OutInstruction)
    );

    if_id_slot #(.DATA_W(DATA_W)) u_skid (
        .Clk          (Clk),
        .Clear        (slot_clear_s),
        .Load         (skid_load_s),
        .DPCPlus4     (InPCPlus4),
        .DInstruction (InInstruction),
        .QPCPlus4     (skid_pc_plus4_s),
        .QInstruction (skid_instruction_s)
    );

    assign InReady    = in_ready_r;
    assign OutValid   = out_valid_r;
    assign StallCount = stall_count_r;

endmodule : if_id_stage

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage. Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge.
module tb_if_id_stage;

    logic        Clk;
    logic        Reset;
    logic        InValid;
    logic [31:0] InPCPlus4;
    logic [31:0] InInstruction;
    logic        InReady;
    logic        OutValid;
    logic [31:0] OutPCPlus4;
    logic [31:0] OutInstruction;
    logic        OutReady;
    logic        Flush;
    logic [15:0] StallCount;

    int checks;
    int errors;

    if_id_stage dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .InValid        (InValid),
        .InPCPlus4      (InPCPlus4),
        .InInstruction  (InInstruction),
        .InReady        (InReady),
        .OutValid       (OutValid),
        .OutPCPlus4     (OutPCPlus4),
        .OutInstruction (OutInstruction),
        .OutReady       (OutReady),
        .Flush          (Flush),
        .StallCount     (StallCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        InValid       = v;
        InPCPlus4     = pc;
        InInstruction = ins;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 32'h0);
        OutReady = 1'b1;
        Flush    = 1'b0;
        do_reset();
        checks++;
        if (OutValid !== 1'b0 || InReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs: OutValid=%b InReady=%b want 0/1", OutValid, InReady);
        end
        checks++;
        if (OutInstruction !== 32'h0 || OutPCPlus4 !== 32'h0 || StallCount !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: instr=%h pc=%h cnt=%0d want 0/0/0", OutInstruction, OutPCPlus4, StallCount);
        end
    endtask

    task automatic test_streaming();
        OutReady = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 32'(4 * i), 32'h2008_0000 + 32'(i));
            step();
            checks++;
            if (OutValid !== 1'b1 || InReady !== 1'b1 ||
                OutInstruction !== (32'h2008_0000 + 32'(i)) || OutPCPlus4 !== 32'(4 * i)) begin
                errors++;
                $display("FAIL stream_%0d: v=%b rdy=%b instr=%h pc=%h want 1/1/%h/%h", i, OutValid, InReady,
                         OutInstruction, OutPCPlus4, 32'h2008_0000 + 32'(i), 32'(4 * i));
            end
        end
        drive(1'b0, 32'h0, 32'h0);
        step();
        checks++;
        if (OutValid !== 1'b0 || StallCount !== 16'd0) begin
            errors++;
            $display("FAIL stream_drain: v=%b cnt=%0d want 0/0", OutValid, StallCount);
        end
    endtask

    task automatic test_stall_fill();
        OutReady = 1'b0;
        drive(1'b1, 32'h104, 32'hAAAA_0001);
        step();
        checks++;
        if (OutValid !== 1'b1 || InReady !== 1'b1 || OutInstruction !== 32'hAAAA_0001) begin
            errors++;
            $display("FAIL fill_first: v=%b rdy=%b instr=%h want 1/1/aaaa0001", OutValid, InReady, OutInstruction);
        end
        drive(1'b1, 32'h108, 32'hAAAA_0002);
        step();
        checks++;
        if (InReady !== 1'b0 || OutInstruction !== 32'hAAAA_0001 || StallCount !== 16'd1) begin
            errors++;
            $display("FAIL fill_second: rdy=%b instr=%h cnt=%0d want 0/aaaa0001/1", InReady, OutInstruction, StallCount);
        end
        drive(1'b1, 32'h10C, 32'hAAAA_0003);
        step();
        step();
        step();
        checks++;
        if (InReady !== 1'b0 || OutInstruction !== 32'hAAAA_0001 || OutPCPlus4 !== 32'h104 || StallCount !== 16'd4) begin
            errors++;
            $display("FAIL fill_hold: rdy=%b instr=%h pc=%h cnt=%0d want 0/aaaa0001/104/4", InReady, OutInstruction,
                     OutPCPlus4, StallCount);
        end
        OutReady = 1'b1;
        step();
        checks++;
        if (OutValid !== 1'b1 || InReady !== 1'b1 || OutInstruction !== 32'hAAAA_0002 || OutPCPlus4 !== 32'h108) begin
            errors++;
            $display("FAIL fill_rel2: v=%b rdy=%b instr=%h pc=%h want 1/1/aaaa0002/108", OutValid, InReady,
                     OutInstruction, OutPCPlus4);
        end
        step();
        drive(1'b0, 32'h0, 32'h0);
        checks++;
        if (OutValid !== 1'b1 || OutInstruction !== 32'hAAAA_0003 || OutPCPlus4 !== 32'h10C) begin
            errors++;
            $display("FAIL fill_rel3: v=%b instr=%h pc=%h want 1/aaaa0003/10c", OutValid, OutInstruction, OutPCPlus4);
        end
        step();
        checks++;
        if (OutValid !== 1'b0 || StallCount !== 16'd4 || OutInstruction !== 32'hAAAA_0003) begin
            errors++;
            $display("FAIL fill_empty: v=%b cnt=%0d instr=%h want 0/4/aaaa0003", OutValid, StallCount, OutInstruction);
        end
    endtask

    task automatic test_flush_two();
        OutReady = 1'b0;
        drive(1'b1, 32'h200, 32'hBBBB_000A);
        step();
        drive(1'b1, 32'h204, 32'hBBBB_000B);
        step();
        checks++;
        if (InReady !== 1'b0 || StallCount !== 16'd5) begin
            errors++;
            $display("FAIL flush_setup: rdy=%b cnt=%0d want 0/5", InReady, StallCount);
        end
        drive(1'b1, 32'h208, 32'hBBBB_000C);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        checks++;
        if (OutValid !== 1'b0 || InReady !== 1'b1 || OutInstruction !== 32'h0 || OutPCPlus4 !== 32'h0) begin
            errors++;
            $display("FAIL flush_out: v=%b rdy=%b instr=%h pc=%h want 0/1/0/0", OutValid, InReady, OutInstruction,
                     OutPCPlus4);
        end
        checks++;
        if (StallCount !== 16'd6) begin
            errors++;
            $display("FAIL flush_cnt: cnt=%0d want 6", StallCount);
        end
        OutReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (OutValid !== 1'b0 || OutInstruction !== 32'h0) begin
                errors++;
                $display("FAIL flush_after_%0d: v=%b instr=%h want 0/0", i, OutValid, OutInstruction);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        OutReady = 1'b0;
        drive(1'b1, 32'h300, 32'hCCCC_0001);
        step();
        drive(1'b1, 32'h304, 32'hCCCC_0002);
        step();
        drive(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (InReady !== 1'b0 || StallCount !== 16'd7) begin
            errors++;
            $display("FAIL rst_mid_setup: rdy=%b cnt=%0d want 0/7", InReady, StallCount);
        end
        do_reset();
        checks++;
        if (OutValid !== 1'b0 || InReady !== 1'b1 || StallCount !== 16'd0 ||
            OutPCPlus4 !== 32'h0 || OutInstruction !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: v=%b rdy=%b cnt=%0d pc=%h instr=%h want 0/1/0/0/0", OutValid, InReady,
                     StallCount, OutPCPlus4, OutInstruction);
        end
        // The old SKID word must not surface once decode starts accepting.
        OutReady = 1'b1;
        step();
        checks++;
        if (OutValid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after: v=%b want 0", OutValid);
        end
    endtask

    task automatic test_simultaneous();
        OutReady = 1'b1;
        drive(1'b1, 32'h400, 32'hDDDD_0001);
        step();
        drive(1'b1, 32'h404, 32'hDDDD_0002);
        step();
        checks++;
        if (OutValid !== 1'b1 || InReady !== 1'b1 || OutInstruction !== 32'hDDDD_0002 || OutPCPlus4 !== 32'h404) begin
            errors++;
            $display("FAIL simul_1: v=%b rdy=%b instr=%h pc=%h want 1/1/dddd0002/404", OutValid, InReady,
                     OutInstruction, OutPCPlus4);
        end
        drive(1'b1, 32'h408, 32'hDDDD_0003);
        step();
        drive(1'b0, 32'h0, 32'h0);
        checks++;
        if (InReady !== 1'b1 || OutInstruction !== 32'hDDDD_0003) begin
            errors++;
            $display("FAIL simul_2: rdy=%b instr=%h want 1/dddd0003", InReady, OutInstruction);
        end
        step();
    endtask

    task automatic test_saturation();
        do_reset();
        OutReady = 1'b0;
        drive(1'b1, 32'h500, 32'hEEEE_0001);
        step();
        drive(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 65534; i++) step();
        checks++;
        if (StallCount !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_pre: cnt=%h want fffe", StallCount);
        end
        step();
        checks++;
        if (StallCount !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hit: cnt=%h want ffff", StallCount);
        end
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (StallCount !== 16'hFFFF || OutInstruction !== 32'hEEEE_0001) begin
            errors++;
            $display("FAIL sat_hold: cnt=%h instr=%h want ffff/eeee0001", StallCount, OutInstruction);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        Reset    = 1'b0;
        Flush    = 1'b0;
        OutReady = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        test_reset();
        test_streaming();
        test_stall_fill();
        test_flush_two();
        test_reset_mid_stall();
        test_simultaneous();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_if_id_stage
